// File: rtl/pooling_pkg.sv
// pooling_pkg: shared types and constants for the average-pooling sequencer
package pooling_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_WORD, LANE, READ, FIN} pool_state_t;
    localparam int LANES = 4;
    // DIV_14x14 is the reciprocal the pooling stage applies; it only holds for DEF_NUM_PIX
    localparam int DEF_NUM_PIX = 196;
    localparam logic [31:0] DIV_14x14 = 32'h0000014e;
endpackage

// File: rtl/pooling_average_ctrl.sv
// pooling_average_ctrl: sequences per-channel read-modify-write accumulation and readout of the pooling BRAM
module pooling_average_ctrl
    import pooling_pkg::*;
#(
    parameter int NUM_PIX = DEF_NUM_PIX,
    parameter int NUM_CH  = 64,
    parameter int ADDR_W  = 32,
    parameter int CH_W    = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    input  logic              ifm_valid,
    output logic              ifm_ready,
    output logic              pool_valid,
    output logic [1:0]        pool_control_data,
    output logic [ADDR_W-1:0] pool_read_addr,
    output logic [ADDR_W-1:0] pool_write_addr,
    output logic              pool_we,
    output logic              pool_init_phase,
    output logic              avg_valid,
    output logic [CH_W-1:0]   avg_ch,
    output logic              done
);
    localparam int PIX_W = $clog2(NUM_PIX + 1);
    localparam int RD_W  = CH_W + 1;
    localparam logic [CH_W-1:0]  GRP_LAST = CH_W'(NUM_CH / LANES - 1);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);
    localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(NUM_CH + 1);

    pool_state_t      state_q, state_d;
    logic [1:0]       k_q, k_d, cd_q, cd_d;
    logic [CH_W-1:0]  grp_q, grp_d, wa_q, wa_d, ach_q, ach_d;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic             we_q, we_d, init_q, init_d, av_q, av_d;
    logic [CH_W-1:0]  lane_ch, rd_ch;
    logic             lane, grp_wrap, rd_act;

    // rd_q: 0 drains the last lane write, 1..NUM_CH issue reads, NUM_CH+1 lets the last value out
    always_comb begin
        lane     = state_q == LANE;
        lane_ch  = CH_W'(int'(grp_q) * LANES + int'(k_q));
        rd_ch    = CH_W'(rd_q - 1'b1);
        rd_act   = state_q == READ && rd_q != '0 && int'(rd_q) <= NUM_CH;
        grp_wrap = grp_q == GRP_LAST;
        state_d  = state_q;
        k_d      = k_q;
        grp_d    = grp_q;
        pix_d    = pix_q;
        rd_d     = rd_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = WAIT_WORD;
                grp_d   = '0;
                pix_d   = '0;
            end
            WAIT_WORD: if (ifm_valid) begin
                state_d = LANE;
                k_d     = '0;
            end
            LANE: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    grp_d   = grp_wrap ? '0 : grp_q + 1'b1;
                    pix_d   = grp_wrap ? pix_q + 1'b1 : pix_q;
                    state_d = grp_wrap && pix_q == PIX_LAST ? READ : WAIT_WORD;
                    rd_d    = '0;
                end
            end
            READ: begin
                rd_d    = rd_q + 1'b1;
                state_d = rd_q == RD_LAST ? FIN : READ;
            end
            default: state_d = IDLE;
        endcase
        we_d   = lane;
        wa_d   = lane_ch;
        cd_d   = k_q;
        init_d = lane && pix_q == '0;
        av_d   = rd_act;
        ach_d  = rd_ch;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            grp_q   <= '0;
            pix_q   <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            cd_q    <= '0;
            init_q  <= 1'b0;
            av_q    <= 1'b0;
            ach_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            grp_q   <= grp_d;
            pix_q   <= pix_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            cd_q    <= cd_d;
            init_q  <= init_d;
            av_q    <= av_d;
            ach_q   <= ach_d;
        end
    end

    assign busy              = state_q != IDLE;
    assign ifm_ready         = state_q == WAIT_WORD;
    assign pool_valid        = ifm_valid & ifm_ready;
    assign done              = state_q == FIN;
    assign pool_read_addr    = lane ? ADDR_W'(lane_ch) : rd_act ? ADDR_W'(rd_ch) : '0;
    assign pool_write_addr   = ADDR_W'(wa_q);
    assign pool_we           = we_q;
    assign pool_control_data = cd_q;
    assign pool_init_phase   = init_q;
    assign avg_valid         = av_q;
    assign avg_ch            = ach_q;
endmodule

// File: tb/tb_pooling_average_ctrl.sv
// tb_pooling_average_ctrl: scoreboard bench with a behavioural pooling BRAM for a small and a default-size sequencer
module tb_pooling_average_ctrl;
    localparam int NP  = 4;
    localparam int NC  = 8;
    localparam int CW  = 3;
    localparam int GNP = 196;
    localparam int GNC = 64;
    localparam int GCW = 6;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, ifm_valid = 1'b0;
    logic        g_start = 1'b0, g_valid = 1'b0;
    logic [31:0] ifm_data = '0;
    always #5 clk = ~clk;

    logic          busy, ifm_ready, pool_valid, pool_we, pool_init_phase, avg_valid, done;
    logic [1:0]    pool_control_data;
    logic [31:0]   pool_read_addr, pool_write_addr;
    logic [CW-1:0] avg_ch;
    logic           g_busy, g_ready, g_pvalid, g_we, g_init, g_av, g_done;
    logic [1:0]     g_cd;
    logic [31:0]    g_ra, g_wa;
    logic [GCW-1:0] g_ach;

    pooling_average_ctrl #(.NUM_PIX(NP), .NUM_CH(NC)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .pool_valid(pool_valid),
        .pool_control_data(pool_control_data), .pool_read_addr(pool_read_addr),
        .pool_write_addr(pool_write_addr), .pool_we(pool_we), .pool_init_phase(pool_init_phase),
        .avg_valid(avg_valid), .avg_ch(avg_ch), .done(done)
    );

    pooling_average_ctrl g_dut (
        .clk(clk), .reset(reset), .start(g_start), .busy(g_busy),
        .ifm_valid(g_valid), .ifm_ready(g_ready), .pool_valid(g_pvalid),
        .pool_control_data(g_cd), .pool_read_addr(g_ra),
        .pool_write_addr(g_wa), .pool_we(g_we), .pool_init_phase(g_init),
        .avg_valid(g_av), .avg_ch(g_ach), .done(g_done)
    );

    int errors = 0, checks = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pooling stage model: input register, 1-cycle read latency, lane-select accumulate
    logic [31:0] in_r, rdat, mem [NC];
    logic [31:0] g_in_r, g_rdat, g_mem [GNC];
    always @(posedge clk) begin
        if (pool_valid) in_r <= ifm_data;
        rdat <= mem[pool_read_addr[CW-1:0]];
        if (pool_we)
            mem[pool_write_addr[CW-1:0]] <= (pool_init_phase ? 32'd0 : rdat) + 32'(in_r[pool_control_data*8 +: 8]);
        if (g_pvalid) g_in_r <= ifm_data;
        g_rdat <= g_mem[g_ra[GCW-1:0]];
        if (g_we)
            g_mem[g_wa[GCW-1:0]] <= (g_init ? 32'd0 : g_rdat) + 32'(g_in_r[g_cd*8 +: 8]);
    end

    logic [63:0] wq[$], aq[$], gaq[$];
    int   done_cnt = 0, g_done_cnt = 0, g_we_cnt = 0;
    logic prev_av = 1'b0;
    always @(negedge clk) begin
        if (pool_we) begin
            if (wq.size() == 0) check("we_extra", 64'(pool_we), 64'd0);
            else check("wr", 64'({pool_init_phase, pool_control_data, pool_write_addr}), wq.pop_front());
        end
        if (avg_valid) begin
            if (aq.size() == 0) check("avg_extra", 64'(avg_valid), 64'd0);
            else check("avg", {29'd0, avg_ch, rdat}, aq.pop_front());
        end
        if (done) begin
            done_cnt++;
            check("done_after_avg", 64'(prev_av), 64'd1);
        end
        prev_av = avg_valid;
        if (g_we) g_we_cnt++;
        if (g_av) begin
            if (gaq.size() == 0) check("g_avg_extra", 64'(g_av), 64'd0);
            else check("g_avg", {26'd0, g_ach, g_rdat}, gaq.pop_front());
        end
        if (g_done) g_done_cnt++;
    end

    task automatic send_word(input logic [31:0] w, input int gaps, input int pix, input int grp);
        int n = 0;
        ifm_data  = w;
        ifm_valid = (gaps == 0);
        while (!ifm_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ifm_ready) begin
            check("ready_timeout", 64'(ifm_ready), 64'd1);
            return;
        end
        repeat (gaps) @(negedge clk);
        ifm_valid = 1'b1;
        for (int k = 0; k < 4; k++) wq.push_back(64'({pix == 0, 2'(k), 32'(grp * 4 + k)}));
        @(negedge clk);
        ifm_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check("rd_addr", 64'(pool_read_addr), 64'(grp * 4 + k));
        end
    endtask

    task automatic run_pass(input logic [31:0] w, input int gaps, input bit extra_start);
        int base = done_cnt;
        int n = 0;
        for (int c = 0; c < NC; c++) aq.push_back({32'(c), 32'(NP) * 32'(w[(c % 4) * 8 +: 8])});
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy", 64'(busy), 64'd1);
        for (int p = 0; p < NP; p++)
            for (int g = 0; g < NC / 4; g++) begin
                if (extra_start && p == 1 && g == 0) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                send_word(w, gaps, p, g);
            end
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done", 64'(done), 64'd1);
        @(negedge clk);
        check("done_once", 64'(done_cnt - base), 64'd1);
        check("idle", 64'({busy, done, ifm_ready}), 64'd0);
        check("avg_left", 64'(aq.size()), 64'd0);
        check("wr_left", 64'(wq.size()), 64'd0);
    endtask

    initial begin
        int n;
        repeat (3) begin
            @(negedge clk);
            check("rst_addr", {pool_read_addr, pool_write_addr}, 64'd0);
            check("rst_ctl", 64'({busy, ifm_ready, pool_valid, pool_control_data, pool_we,
                                  pool_init_phase, avg_valid, avg_ch, done}), 64'd0);
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("idle_after_rst", 64'({busy, ifm_ready}), 64'd0);
        end
        run_pass(32'h04030201, 0, 1'b0);
        run_pass(32'hFFFFFFFF, 0, 1'b0);
        run_pass(32'hFFFFFFFF, 3, 1'b0);
        // abort in lane 2 of pixel 2; only lanes 0 and 1 of that word get written
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int g = 0; g < NC / 4; g++) send_word(32'hFFFFFFFF, 0, p, g);
        ifm_valid = 1'b1;
        n = 0;
        while (!ifm_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_ready", 64'(ifm_ready), 64'd1);
        for (int k = 0; k < 2; k++) wq.push_back(64'({1'b0, 2'(k), 32'(k)}));
        @(negedge clk) ifm_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        check("mid_rst_we", 64'(pool_we), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_wr_left", 64'(wq.size()), 64'd0);
        run_pass(32'h01010101, 0, 1'b0);
        run_pass(32'hFFFFFFFF, 0, 1'b1);
        // default-size pass with a source that is always valid
        for (int c = 0; c < GNC; c++) gaq.push_back({32'(c), 32'(GNP * (c % 4 + 1))});
        ifm_data = 32'h04030201;
        g_valid  = 1'b1;
        @(negedge clk) g_start = 1'b1;
        @(negedge clk) g_start = 1'b0;
        check("g_busy", 64'({g_busy, g_ready}), 64'd3);
        n = 0;
        while (!g_done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("g_done", 64'(g_done), 64'd1);
        @(negedge clk);
        g_valid = 1'b0;
        check("g_done_once", 64'(g_done_cnt), 64'd1);
        check("g_avg_left", 64'(gaq.size()), 64'd0);
        check("g_we_cnt", 64'(g_we_cnt), 64'(GNP * GNC));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
